// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core
// load/store unit (port 0) and the loader (port 1); one access at a time.
module dmem_port_arbiter #(
   parameter int ADDR_W        = 10,
   parameter int DATA_W        = 32,
   parameter int ACCESS_CYCLES = 1
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              grant_id,
   output logic              mem_MemRW,
   output logic [ADDR_W-1:0] mem_Addr,
   output logic [DATA_W-1:0] mem_DataW,
   input  logic [DATA_W-1:0] mem_DataR
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} ArbState;

   localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

   ArbState           state;
   ArbState           nextState;
   logic [3:0]        cnt;
   logic              latWe;
   logic [ADDR_W-1:0] latAddr;
   logic [DATA_W-1:0] latData;
   logic              lastGrant;
   logic              anyReq;
   logic              winner;
   logic              memWrite;

   // On a tie the port that did not win last time is served, giving strict alternation.
   always_comb begin
      anyReq = req0 | req1;
      winner = 1'b0;
      if (req0 && req1) begin
         winner = ~lastGrant;
      end else if (req1) begin
         winner = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // The write strobe is decoded from state so a reset mid-access kills it at once.
   always_comb begin
      nextState = state;
      memWrite  = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (anyReq) begin
               nextState = ACCESS;
            end
         end
         ACCESS: begin
            busy     = 1'b1;
            memWrite = latWe && (cnt == 4'd0);
            if (cnt == 4'd0) begin
               nextState = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         cnt       <= 4'd0;
         latWe     <= 1'b0;
         latAddr   <= '0;
         latData   <= '0;
         grant_id  <= 1'b0;
         lastGrant <= 1'b1;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         rdata     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (anyReq) begin
                  latWe    <= winner ? we1 : we0;
                  latAddr  <= winner ? addr1 : addr0;
                  latData  <= winner ? wdata1 : wdata0;
                  grant_id <= winner;
                  cnt      <= CNT_INIT;
               end
            end
            ACCESS: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  if (!latWe) begin
                     rdata <= mem_DataR;
                  end
                  ack0      <= ~grant_id;
                  ack1      <= grant_id;
                  lastGrant <= grant_id;
               end
            end
            DONE: begin
               ack0 <= 1'b0;
               ack1 <= 1'b0;
            end
            default: begin
               ack0 <= 1'b0;
               ack1 <= 1'b0;
            end
         endcase
      end
   end

   assign mem_MemRW = memWrite;
   assign mem_Addr  = latAddr;
   assign mem_DataW = latData;

endmodule
